// File: rtl/bitonic_sort_ctrl_pkg.sv
// Shared types and the per-step network tables for the 8-element bitonic sorter.
package bitonic_sort_ctrl_pkg;
  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  localparam int NUM_ELEM  = 8;
  localparam int NUM_STEPS = 6;

  // Block size k picks pair direction, distance j picks the partner.
  localparam int STEP_K [NUM_STEPS] = '{2, 4, 4, 8, 8, 8};
  localparam int STEP_J [NUM_STEPS] = '{1, 2, 1, 4, 2, 1};
endpackage

// File: rtl/bitonic_sort_ctrl_if.sv
// Serial load / serial unload handshake bundle of the bitonic sorter.
interface bitonic_sort_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] number_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] number_out;

  modport master (output in_valid, number_in, out_ready,
                  input  in_ready, out_valid, number_out);
  modport slave  (input  in_valid, number_in, out_ready,
                  output in_ready, out_valid, number_out);
endinterface

// File: rtl/bitonic_cx_layer.sv
// One layer of four compare-exchange units; step selects which network layer it plays.
module bitonic_cx_layer
  import bitonic_sort_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [NUM_ELEM-1:0][WIDTH-1:0] din,
  input  logic [2:0]                     step,
  output logic [NUM_ELEM-1:0][WIDTH-1:0] dout
);
  logic [3:0]       k;
  logic [2:0]       j, lo, hi, uu;
  logic [WIDTH-1:0] a, b;
  logic             asc, swap;

  always_comb begin
    dout = din;
    k    = '0;
    j    = '0;
    lo   = '0;
    hi   = '0;
    uu   = '0;
    a    = '0;
    b    = '0;
    asc  = 1'b1;
    swap = 1'b0;
    if (int'(step) < NUM_STEPS) begin
      k = 4'(STEP_K[step]);
      j = 3'(STEP_J[step]);
      for (int u = 0; u < NUM_ELEM / 2; u++) begin
        // u-th index with bit j clear: insert a zero at bit position log2(j).
        uu   = 3'(u);
        lo   = ((uu & ~(j - 3'd1)) << 1) | (uu & (j - 3'd1));
        hi   = lo + j;
        asc  = (({1'b0, lo} & k) == 4'd0);
        a    = din[lo];
        b    = din[hi];
        swap = asc ? (a > b) : (a < b);
        dout[lo] = swap ? b : a;
        dout[hi] = swap ? a : b;
      end
    end
  end
endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Sequential 8-element bitonic sorter: load serially, 6 shared-layer steps, unload serially.
module bitonic_sort_ctrl
  import bitonic_sort_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit DESCEND = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  bitonic_sort_ctrl_if.slave  bus,
  output logic                busy
);
  state_t                        state, state_nxt;
  logic [2:0]                    in_cnt, step, out_cnt, rd_idx;
  logic [NUM_ELEM-1:0][WIDTH-1:0] r, r_sorted;
  logic                          in_hs, out_hs;

  assign in_hs  = bus.in_valid & bus.in_ready;
  assign out_hs = bus.out_valid & bus.out_ready;
  assign rd_idx = DESCEND ? (3'd7 - out_cnt) : out_cnt;

  bitonic_cx_layer #(.WIDTH(WIDTH)) u_layer (
    .din  (r),
    .step (step),
    .dout (r_sorted)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (in_hs && in_cnt == 3'd7)   state_nxt = SORT;
      SORT:    if (step == 3'd5)              state_nxt = OUT;
      OUT:     if (out_hs && out_cnt == 3'd7) state_nxt = LOAD;
      default:                                state_nxt = LOAD;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state == LOAD);
    bus.out_valid  = (state == OUT);
    busy           = (state != LOAD);
    bus.number_out = (state == OUT) ? r[rd_idx] : '0;
  end

  // Counters wrap naturally at 8, so the last handshake leaves them at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt  <= '0;
      step    <= '0;
      out_cnt <= '0;
      r       <= '0;
    end else begin
      unique case (state)
        LOAD: if (in_hs) begin
          r[in_cnt] <= bus.number_in;
          in_cnt    <= in_cnt + 3'd1;
          step      <= '0;
        end
        SORT: begin
          r    <= r_sorted;
          step <= step + 3'd1;
          if (step == 3'd5) begin
            step    <= '0;
            out_cnt <= '0;
          end
        end
        OUT:  if (out_hs) out_cnt <= out_cnt + 3'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed and random checks of bitonic_sort_ctrl; ascending and descending instances run in lockstep.
module tb_bitonic_sort_ctrl;
  typedef logic [7:0] vec_t [8];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] number_in = 8'd0;
  logic       out_ready = 1'b0;
  logic       busy_a, busy_d;
  int         total = 0;
  int         bad = 0;

  bitonic_sort_ctrl_if #(.WIDTH(8)) ba ();
  bitonic_sort_ctrl_if #(.WIDTH(8)) bd ();

  assign ba.in_valid  = in_valid;
  assign ba.number_in = number_in;
  assign ba.out_ready = out_ready;
  assign bd.in_valid  = in_valid;
  assign bd.number_in = number_in;
  assign bd.out_ready = out_ready;

  bitonic_sort_ctrl #(.WIDTH(8), .DESCEND(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(ba), .busy(busy_a));
  bitonic_sort_ctrl #(.WIDTH(8), .DESCEND(1'b1)) dut_d (
    .clk(clk), .reset(reset), .bus(bd), .busy(busy_d));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sort_ref(input vec_t v, output vec_t s);
    logic [7:0] t;
    s = v;
    for (int i = 1; i < 8; i++)
      for (int m = i; m > 0 && s[m-1] > s[m]; m--) begin
        t = s[m]; s[m] = s[m-1]; s[m-1] = t;
      end
  endtask

  task automatic load_vals(input vec_t v, input int n, input bit gap, input bit junk);
    int g;
    for (int i = 0; i < n; i++) begin
      if (gap && (i % 3 == 1)) begin
        in_valid = 1'b0; number_in = 8'hEE; tick;
      end
      in_valid = 1'b1; number_in = v[i];
      g = 0;
      while (ba.in_ready !== 1'b1 && g < 50) begin tick; g++; end
      if (g >= 50) begin
        total++; bad++;
        $display("FAIL load_timeout idx=%0d in_ready=%b want=1", i, ba.in_ready);
      end
      tick;
    end
    if (junk) number_in = 8'hAA;
    else      in_valid = 1'b0;
  endtask

  task automatic do_batch(input vec_t v, input vec_t e, input bit gap, input bit stall,
                          input bit junk, input string tag);
    int lat, lowcnt, n, c;
    load_vals(v, 8, gap, junk);
    lat = 0; lowcnt = 0;
    while (ba.out_valid !== 1'b1 && lat < 40) begin
      if (ba.in_ready === 1'b0 && busy_a === 1'b1) lowcnt++;
      tick; lat++;
    end
    total++;
    if (lat != 6) begin bad++; $display("FAIL %s latency got=%0d want=6", tag, lat); end
    total++;
    if (lowcnt != 6) begin bad++; $display("FAIL %s sort_cycles got=%0d want=6", tag, lowcnt); end
    n = 0; c = 0;
    while (n < 8 && c < 200) begin
      out_ready = stall ? (c % 3 == 0) : 1'b1;
      if (n == 7 && out_ready) in_valid = 1'b0;
      total++;
      if (ba.number_out !== e[n]) begin
        bad++; $display("FAIL %s asc[%0d] got=%0d want=%0d", tag, n, ba.number_out, e[n]);
      end
      total++;
      if (bd.number_out !== e[7-n]) begin
        bad++; $display("FAIL %s desc[%0d] got=%0d want=%0d", tag, n, bd.number_out, e[7-n]);
      end
      total++;
      if (ba.in_ready !== 1'b0 || busy_a !== 1'b1) begin
        bad++; $display("FAIL %s out_phase in_ready=%b busy=%b want=0/1", tag, ba.in_ready, busy_a);
      end
      if (out_ready && ba.out_valid) n++;
      tick; c++;
    end
    total++;
    if (n != 8) begin bad++; $display("FAIL %s out_count got=%0d want=8", tag, n); end
    total++;
    if (ba.out_valid !== 1'b0 || bd.out_valid !== 1'b0 || ba.in_ready !== 1'b1 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL %s post_batch out_valid=%b/%b in_ready=%b busy=%b want=0/0/1/0",
               tag, ba.out_valid, bd.out_valid, ba.in_ready, busy_a);
    end
  endtask

  task automatic chk_idle(input string tag);
    total++;
    if (ba.in_ready !== 1'b1 || bd.in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready got=%b/%b want=1", tag, ba.in_ready, bd.in_ready);
    end
    total++;
    if (ba.out_valid !== 1'b0 || bd.out_valid !== 1'b0) begin
      bad++; $display("FAIL %s out_valid got=%b/%b want=0", tag, ba.out_valid, bd.out_valid);
    end
    total++;
    if (busy_a !== 1'b0 || busy_d !== 1'b0) begin
      bad++; $display("FAIL %s busy got=%b/%b want=0", tag, busy_a, busy_d);
    end
    total++;
    if (ba.number_out !== 8'd0 || bd.number_out !== 8'd0) begin
      bad++; $display("FAIL %s number_out got=%0d/%0d want=0", tag, ba.number_out, bd.number_out);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick; tick;
    chk_idle("reset");
    reset = 1'b0;
    tick;
    chk_idle("reset_release");
  endtask

  task automatic test_basic;
    do_batch('{5, 3, 8, 1, 7, 2, 6, 4}, '{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0, 1'b0, 1'b1, "basic");
  endtask

  task automatic test_extremes;
    do_batch('{255, 0, 255, 0, 128, 128, 1, 254}, '{0, 0, 1, 128, 128, 254, 255, 255},
             1'b0, 1'b0, 1'b0, "extremes");
    do_batch('{9, 9, 9, 9, 9, 9, 9, 9}, '{9, 9, 9, 9, 9, 9, 9, 9}, 1'b0, 1'b0, 1'b0, "all_equal");
  endtask

  task automatic test_order;
    do_batch('{0, 1, 2, 3, 4, 5, 6, 7}, '{0, 1, 2, 3, 4, 5, 6, 7}, 1'b0, 1'b0, 1'b0, "sorted");
    do_batch('{7, 6, 5, 4, 3, 2, 1, 0}, '{0, 1, 2, 3, 4, 5, 6, 7}, 1'b0, 1'b0, 1'b0, "reverse");
  endtask

  task automatic test_backpressure;
    do_batch('{200, 17, 17, 3, 99, 0, 64, 250}, '{0, 3, 17, 17, 64, 99, 200, 250},
             1'b1, 1'b1, 1'b0, "backpressure");
  endtask

  task automatic test_reset_mid;
    load_vals('{1, 2, 3, 4, 0, 0, 0, 0}, 4, 1'b0, 1'b0);
    reset = 1'b1; tick; reset = 1'b0;
    chk_idle("reset_in_load");
    do_batch('{8, 7, 6, 5, 4, 3, 2, 1}, '{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0, 1'b0, 1'b0, "after_load_reset");
    load_vals('{11, 12, 13, 14, 15, 16, 17, 18}, 8, 1'b0, 1'b0);
    tick; tick;
    reset = 1'b1; tick; reset = 1'b0;
    chk_idle("reset_in_sort");
    do_batch('{40, 30, 20, 10, 0, 50, 60, 70}, '{0, 10, 20, 30, 40, 50, 60, 70},
             1'b0, 1'b0, 1'b0, "after_sort_reset");
  endtask

  task automatic test_back_to_back;
    vec_t e1;
    int   w, n, c;
    e1 = '{1, 2, 3, 4, 6, 7, 8, 9};
    load_vals('{9, 1, 8, 2, 7, 3, 6, 4}, 8, 1'b0, 1'b0);
    w = 0;
    while (ba.out_valid !== 1'b1 && w < 40) begin tick; w++; end
    total++;
    if (w != 6) begin bad++; $display("FAIL b2b latency got=%0d want=6", w); end
    in_valid = 1'b1; number_in = 8'd100; out_ready = 1'b1;
    n = 0; c = 0;
    while (n < 8 && c < 50) begin
      total++;
      if (ba.in_ready !== 1'b0) begin bad++; $display("FAIL b2b in_ready[%0d] got=%b want=0", n, ba.in_ready); end
      total++;
      if (ba.number_out !== e1[n]) begin
        bad++; $display("FAIL b2b first[%0d] got=%0d want=%0d", n, ba.number_out, e1[n]);
      end
      if (ba.out_valid === 1'b1) n++;
      tick; c++;
    end
    total++;
    if (ba.in_ready !== 1'b1 || ba.out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b reopen in_ready=%b out_valid=%b want=1/0", ba.in_ready, ba.out_valid);
    end
    do_batch('{100, 50, 150, 25, 75, 125, 175, 0}, '{0, 25, 50, 75, 100, 125, 150, 175},
             1'b0, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_random;
    vec_t v, e;
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(0, 255));
      sort_ref(v, e);
      do_batch(v, e, 1'b0, 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_order;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
